// File: rtl/priority_pkg.sv
// rtl/priority_pkg.sv - shared types and sizing helpers for the priority decoder
package priority_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } pd_state_t;

    // One counter serves both the HOLD and GAP phases, so size it for the larger.
    function automatic int pd_cnt_w(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pd_fifo.sv
// rtl/pd_fifo.sv - synchronous FIFO buffering encoded indices
module pd_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/priority_decoder_sva.sv
// rtl/priority_decoder_sva.sv - invariant checker bound into every priority_decoder
module priority_decoder_sva #(
    parameter int N_OUT = 4,
    parameter int HOLD  = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N_OUT-1:0] out,
    input logic             out_valid,
    input logic             done,
    input logic             in_ready,
    input logic             push
);
    int   run;
    logic mid;

    // run counts completed cycles of the current strobe; mid flags an unfinished one.
    always_ff @(posedge clk) begin
        if (!rst_n || !out_valid || done) run <= 0;
        else                              run <= run + 1;
        if (!rst_n) mid <= 1'b0;
        else        mid <= out_valid && !done;
    end

    a_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out));
    a_valid:    assert property (@(posedge clk) disable iff (!rst_n) out_valid == (|out));
    a_done:     assert property (@(posedge clk) disable iff (!rst_n) done |-> out_valid);
    a_len_done: assert property (@(posedge clk) disable iff (!rst_n) done |-> run == HOLD - 1);
    a_len_max:  assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> run < HOLD);
    a_len_min:  assert property (@(posedge clk) disable iff (!rst_n) mid |-> out_valid);
    a_push:     assert property (@(posedge clk) disable iff (!rst_n) push |-> in_ready);

endmodule

bind priority_decoder priority_decoder_sva #(.N_OUT(N_OUT), .HOLD(HOLD)) u_sva (
    .clk       (clk),
    .rst_n     (rst_n),
    .out       (out),
    .out_valid (out_valid),
    .done      (done),
    .in_ready  (in_ready),
    .push      (push)
);

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - replays queued indices as timed one-hot strobes
module priority_decoder
    import priority_pkg::*;
#(
    parameter int IDX_W = 2,
    parameter int N_OUT = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OUT-1:0] out,
    output logic             out_valid,
    output logic             done,
    output logic             err,
    output logic             busy
);
    localparam int               CNT_W  = pd_cnt_w(HOLD, GAP);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    pd_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_OUT-1:0] line, line_nxt, dec;
    logic [IDX_W-1:0] head;
    logic             err_nxt;
    logic             push, pop, full, empty;
    logic             last, load_pt, idx_ok;

    assign in_ready = !full;
    assign push     = in_valid && !full;

    pd_fifo #(.WIDTH(IDX_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_idx),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Out-of-range indices decode to all-zero, which doubles as the range check.
    always_comb begin
        dec = '0;
        for (int i = 0; i < N_OUT; i++) dec[i] = (head == IDX_W'(i));
    end
    assign idx_ok = |dec;

    assign last    = (cnt == '0);
    assign load_pt = (state == IDLE) ||
                     (state == DRIVE && last && GAP == 0) ||
                     (state == priority_pkg::GAP && last);
    assign pop     = load_pt && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            line  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            line  <= line_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        line_nxt  = line;
        err_nxt   = 1'b0;
        case (state)
            DRIVE: begin
                if (!last) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (GAP > 0) begin
                    state_nxt = priority_pkg::GAP;
                    cnt_nxt   = GAP_M1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            priority_pkg::GAP: begin
                if (!last) cnt_nxt = cnt - CNT_W'(1);
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (pop) begin
            if (idx_ok) begin
                state_nxt = DRIVE;
                cnt_nxt   = HOLD_M1;
                line_nxt  = dec;
            end else begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
            end
        end
    end

    always_comb begin
        out       = '0;
        done      = 1'b0;
        if (state == DRIVE) begin
            out  = line;
            done = last;
        end
        out_valid = |out;
        busy      = !empty || (state != IDLE);
    end

endmodule

// File: tb/tb_priority_decoder.sv
// tb/tb_priority_decoder.sv - self-checking bench for priority_decoder
module tb_priority_decoder;
    localparam int HOLD  = 3;
    localparam int GAP   = 1;
    localparam int DEPTH = 2;
    localparam int N_OUT = 4;

    typedef struct {
        logic [3:0] o;
        logic       d;
        logic       e;
        logic       act;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ia = '0, ib = '0, ic = '0;
    logic       va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic [3:0] out_a, out_b;
    logic [2:0] out_c;
    logic       rdy_a, ov_a, done_a, err_a, busy_a;
    logic       rdy_b, ov_b, done_b, err_b, busy_b;
    logic       rdy_c, ov_c, done_c, err_c, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_decoder #(.IDX_W(2), .N_OUT(N_OUT), .HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_idx(ia), .in_valid(va), .in_ready(rdy_a),
        .out(out_a), .out_valid(ov_a), .done(done_a), .err(err_a), .busy(busy_a));

    priority_decoder #(.IDX_W(2), .N_OUT(4), .HOLD(3), .GAP(0), .DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_idx(ib), .in_valid(vb), .in_ready(rdy_b),
        .out(out_b), .out_valid(ov_b), .done(done_b), .err(err_b), .busy(busy_b));

    priority_decoder #(.IDX_W(2), .N_OUT(3), .HOLD(3), .GAP(1), .DEPTH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_idx(ic), .in_valid(vc), .in_ready(rdy_c),
        .out(out_c), .out_valid(ov_c), .done(done_c), .err(err_c), .busy(busy_c));

    task automatic test_reset();
        rst_n = 1'b0; va = 1'b1; vb = 1'b1; vc = 1'b1; ia = 2'd1; ib = 2'd1; ic = 2'd1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        checks++; if (out_a !== 4'b0000) begin errors++; $display("FAIL reset_out got %b exp 0000", out_a); end
        checks++; if ({ov_a, done_a, err_a, busy_a} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {ov_a, done_a, err_a, busy_a}); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", rdy_a); end
        checks++; if ({out_b, out_c} !== 7'd0) begin errors++; $display("FAIL reset_out_bc got %b exp 0", {out_b, out_c}); end
        va = 1'b0; vb = 1'b0; vc = 1'b0; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin errors++; $display("FAIL reset_nopush busy got %b exp 000", {busy_a, busy_b, busy_c}); end
        checks++; if (out_a !== 4'b0000) begin errors++; $display("FAIL reset_after_out got %b exp 0000", out_a); end
    endtask

    task automatic test_single();
        logic [3:0] e_o [6] = '{4'd0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0};
        logic       e_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       e_b [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++; if (out_a !== e_o[c-1]) begin errors++; $display("FAIL single_out c=%0d got %b exp %b", c, out_a, e_o[c-1]); end
                checks++; if (done_a !== e_d[c-1]) begin errors++; $display("FAIL single_done c=%0d got %b exp %b", c, done_a, e_d[c-1]); end
                checks++; if (busy_a !== e_b[c-1]) begin errors++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy_a, e_b[c-1]); end
                checks++; if (ov_a !== (e_o[c-1] != 4'd0)) begin errors++; $display("FAIL single_valid c=%0d got %b", c, ov_a); end
            end
            va = (c == 0); ia = 2'd2;
        end
        va = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] pushes [3] = '{2'd3, 2'd0, 2'd1};
        logic [3:0] e_o [13] = '{4'd0, 4'd8, 4'd8, 4'd8, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0};
        logic       e_r [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int ndone = 0;
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++; if (out_a !== e_o[c-1]) begin errors++; $display("FAIL b2b_out c=%0d got %b exp %b", c, out_a, e_o[c-1]); end
                checks++; if (rdy_a !== e_r[c-1]) begin errors++; $display("FAIL b2b_ready c=%0d got %b exp %b", c, rdy_a, e_r[c-1]); end
                if (done_a === 1'b1) ndone++;
            end
            va = (c < 3);
            if (c < 3) ia = pushes[c];
        end
        va = 1'b0;
        checks++; if (ndone != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", ndone); end
    endtask

    task automatic test_gap0();
        logic [3:0] e_o [8] = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd0};
        logic       e_d [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++; if (out_b !== e_o[c-1]) begin errors++; $display("FAIL gap0_out c=%0d got %b exp %b", c, out_b, e_o[c-1]); end
                checks++; if (done_b !== e_d[c-1]) begin errors++; $display("FAIL gap0_done c=%0d got %b exp %b", c, done_b, e_d[c-1]); end
                checks++; if (ov_b !== (e_o[c-1] != 4'd0)) begin errors++; $display("FAIL gap0_valid c=%0d got %b", c, ov_b); end
            end
            vb = (c < 2); ib = (c == 0) ? 2'd1 : 2'd2;
        end
        vb = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [2:0] e_o [6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
        logic       e_e [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       e_d [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++; if (out_c !== e_o[c-1]) begin errors++; $display("FAIL oor_out c=%0d got %b exp %b", c, out_c, e_o[c-1]); end
                checks++; if (err_c !== e_e[c-1]) begin errors++; $display("FAIL oor_err c=%0d got %b exp %b", c, err_c, e_e[c-1]); end
                checks++; if (done_c !== e_d[c-1]) begin errors++; $display("FAIL oor_done c=%0d got %b exp %b", c, done_c, e_d[c-1]); end
                checks++; if (ov_c !== (e_o[c-1] != 3'd0)) begin errors++; $display("FAIL oor_valid c=%0d got %b", c, ov_c); end
            end
            vc = (c < 2); ic = (c == 0) ? 2'd3 : 2'd0;
        end
        vc = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++; if (out_a !== 4'b0100) begin errors++; $display("FAIL rmid_drive got %b exp 0100", out_a); end
            end
            if (c >= 4) begin
                checks++; if (out_a !== 4'b0000) begin errors++; $display("FAIL rmid_out c=%0d got %b exp 0000", c, out_a); end
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rmid_busy c=%0d got %b exp 0", c, busy_a); end
                checks++; if ({done_a, err_a} !== 2'b00) begin errors++; $display("FAIL rmid_flags c=%0d got %b exp 00", c, {done_a, err_a}); end
            end
            if (c == 4) begin
                checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", rdy_a); end
            end
            va = (c < 2); ia = (c == 0) ? 2'd2 : 2'd1;
            rst_n = !(c == 3 || c == 4);
        end
        va = 1'b0; rst_n = 1'b1;
    endtask

    // Reference model: a queue of accepted indices and a queue of upcoming per-cycle outputs.
    task automatic test_random();
        int   q[$];
        rec_t sched[$];
        rec_t cur, r;
        int   h;
        bit   acc;
        @(negedge clk); rst_n = 1'b0; va = 1'b0;
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (sched.size() > 0) cur = sched[0];
            else begin cur.o = 4'd0; cur.d = 1'b0; cur.e = 1'b0; cur.act = 1'b0; end
            checks++; if (out_a !== cur.o) begin errors++; $display("FAIL rand_out c=%0d got %b exp %b", c, out_a, cur.o); end
            checks++; if (done_a !== cur.d) begin errors++; $display("FAIL rand_done c=%0d got %b exp %b", c, done_a, cur.d); end
            checks++; if (err_a !== cur.e) begin errors++; $display("FAIL rand_err c=%0d got %b exp %b", c, err_a, cur.e); end
            checks++; if (busy_a !== (q.size() > 0 || cur.act)) begin errors++; $display("FAIL rand_busy c=%0d got %b", c, busy_a); end
            checks++; if (rdy_a !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready c=%0d got %b", c, rdy_a); end
            if (!(va && !(q.size() < DEPTH))) begin
                va = ($urandom_range(0, 2) != 0);
                ia = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            acc = va && (q.size() < DEPTH);
            if (sched.size() > 0) void'(sched.pop_front());
            if (sched.size() == 0 && q.size() > 0) begin
                h = q.pop_front();
                if (h < N_OUT) begin
                    for (int k = 0; k < HOLD; k++) begin
                        r.o = 4'(1 << h); r.d = (k == HOLD - 1); r.e = 1'b0; r.act = 1'b1;
                        sched.push_back(r);
                    end
                    for (int k = 0; k < GAP; k++) begin
                        r.o = 4'd0; r.d = 1'b0; r.e = 1'b0; r.act = 1'b1;
                        sched.push_back(r);
                    end
                end else begin
                    r.o = 4'd0; r.d = 1'b0; r.e = 1'b1; r.act = 1'b0;
                    sched.push_back(r);
                end
            end
            if (acc) q.push_back(int'(ia));
            @(negedge clk);
        end
        va = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
